// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline register bundle: decode/forwarding inputs and EX-side outputs.
// The master modport is the decode/hazard side and the slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int N = 32
);
    logic         i_stall;
    logic         i_flush;
    logic         i_in_vld;
    logic [N-1:0] i_rs_dat;
    logic [N-1:0] i_rt_dat;
    logic [N-1:0] i_imm_ext;
    logic [4:0]   i_rs;
    logic [4:0]   i_rt;
    logic [4:0]   i_rd;
    logic         i_alu_src;
    logic         i_reg_dst;
    logic         i_reg_write;
    logic         i_mem_write;
    logic         i_mem_to_reg;
    logic [2:0]   i_alu_ctrl;
    logic         i_exm_reg_write;
    logic         i_mwb_reg_write;
    logic [4:0]   i_exm_rd;
    logic [4:0]   i_mwb_rd;
    logic [N-1:0] i_exm_result;
    logic [N-1:0] i_mwb_result;

    logic [N-1:0] o_a;
    logic [N-1:0] o_b;
    logic [2:0]   o_alu_ctrl;
    logic [N-1:0] o_write_dat;
    logic [4:0]   o_write_reg;
    logic         o_reg_write;
    logic         o_mem_write;
    logic         o_mem_to_reg;
    logic         o_out_vld;
    logic         o_load_use_stall;

    modport master (
        output i_stall, i_flush, i_in_vld, i_rs_dat, i_rt_dat, i_imm_ext,
               i_rs, i_rt, i_rd, i_alu_src, i_reg_dst, i_reg_write, i_mem_write,
               i_mem_to_reg, i_alu_ctrl, i_exm_reg_write, i_mwb_reg_write,
               i_exm_rd, i_mwb_rd, i_exm_result, i_mwb_result,
        input  o_a, o_b, o_alu_ctrl, o_write_dat, o_write_reg, o_reg_write,
               o_mem_write, o_mem_to_reg, o_out_vld, o_load_use_stall
    );

    modport slave (
        input  i_stall, i_flush, i_in_vld, i_rs_dat, i_rt_dat, i_imm_ext,
               i_rs, i_rt, i_rd, i_alu_src, i_reg_dst, i_reg_write, i_mem_write,
               i_mem_to_reg, i_alu_ctrl, i_exm_reg_write, i_mwb_reg_write,
               i_exm_rd, i_mwb_rd, i_exm_result, i_mwb_result,
        output o_a, o_b, o_alu_ctrl, o_write_dat, o_write_reg, o_reg_write,
               o_mem_write, o_mem_to_reg, o_out_vld, o_load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding (enabled by macro ID_EX_FWD_EN) and load-use detection.
// Latency: 1 cycle capture; operands/forwarding and o_load_use_stall are combinational from state.
// Backpressure: i_stall holds all state, i_flush inserts a bubble and overrides i_stall.
module id_ex_stage #(
    parameter int N = 32
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic [N-1:0] r_rs_dat;
    logic [N-1:0] r_rt_dat;
    logic [N-1:0] r_imm;
    logic [4:0]   r_rs;
    logic [4:0]   r_rt;
    logic [4:0]   r_rd;
    logic         r_alu_src;
    logic         r_reg_dst;
    logic [2:0]   r_alu_ctrl;
    logic         r_reg_write;
    logic         r_mem_write;
    logic         r_mem_to_reg;
    logic         r_vld;

    logic [N-1:0] w_fa;
    logic [N-1:0] w_fb;
    logic [4:0]   w_write_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs_dat     <= '0;
            r_rt_dat     <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_ctrl   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_vld        <= 1'b0;
        end else if (bus.i_flush) begin
            // Bubble: only the side-effecting controls matter, datapath is left as is.
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_vld        <= 1'b0;
        end else if (!bus.i_stall) begin
            r_rs_dat     <= bus.i_rs_dat;
            r_rt_dat     <= bus.i_rt_dat;
            r_imm        <= bus.i_imm_ext;
            r_rs         <= bus.i_rs;
            r_rt         <= bus.i_rt;
            r_rd         <= bus.i_rd;
            r_alu_src    <= bus.i_alu_src;
            r_reg_dst    <= bus.i_reg_dst;
            r_alu_ctrl   <= bus.i_alu_ctrl;
            r_reg_write  <= bus.i_in_vld & bus.i_reg_write;
            r_mem_write  <= bus.i_in_vld & bus.i_mem_write;
            r_mem_to_reg <= bus.i_in_vld & bus.i_mem_to_reg;
            r_vld        <= bus.i_in_vld;
        end
    end

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it is checked first; r0 is hardwired zero.
    always_comb begin
        w_fa = r_rs_dat;
        if (bus.i_exm_reg_write && (bus.i_exm_rd == r_rs) && (r_rs != 5'd0))
            w_fa = bus.i_exm_result;
        else if (bus.i_mwb_reg_write && (bus.i_mwb_rd == r_rs) && (r_rs != 5'd0))
            w_fa = bus.i_mwb_result;
    end

    always_comb begin
        w_fb = r_rt_dat;
        if (bus.i_exm_reg_write && (bus.i_exm_rd == r_rt) && (r_rt != 5'd0))
            w_fb = bus.i_exm_result;
        else if (bus.i_mwb_reg_write && (bus.i_mwb_rd == r_rt) && (r_rt != 5'd0))
            w_fb = bus.i_mwb_result;
    end
`else
    logic w_unused_fwd;

    assign w_fa = r_rs_dat;
    assign w_fb = r_rt_dat;
    assign w_unused_fwd = ^{bus.i_exm_reg_write, bus.i_mwb_reg_write, bus.i_exm_rd,
                            bus.i_mwb_rd, bus.i_exm_result, bus.i_mwb_result, r_rs};
`endif

    assign w_write_reg = r_reg_dst ? r_rd : r_rt;

    assign bus.o_a          = w_fa;
    assign bus.o_b          = r_alu_src ? r_imm : w_fb;
    assign bus.o_write_dat  = w_fb;
    assign bus.o_write_reg  = w_write_reg;
    assign bus.o_alu_ctrl   = r_alu_ctrl;
    assign bus.o_reg_write  = r_reg_write;
    assign bus.o_mem_write  = r_mem_write;
    assign bus.o_mem_to_reg = r_mem_to_reg;
    assign bus.o_out_vld    = r_vld;

    // A load still in EX cannot feed the incoming instruction; decode must hold it a cycle.
    assign bus.o_load_use_stall = bus.i_in_vld & r_vld & r_mem_to_reg &
                                  (w_write_reg != 5'd0) &
                                  ((w_write_reg == bus.i_rs) || (w_write_reg == bus.i_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-computed expectations, a negedge monitor pops and checks.
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    id_ex_stage_if #(.N(32)) bus ();

    id_ex_stage #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [2:0]  aluc;
        logic        rw;
        logic        mw;
        logic        mtr;
        logic        vld;
        logic        lus;
        logic        dp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s got %h required %h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "out_vld", 32'(bus.o_out_vld), 32'(e.vld));
            cmp(e.nm, "reg_write", 32'(bus.o_reg_write), 32'(e.rw));
            cmp(e.nm, "mem_write", 32'(bus.o_mem_write), 32'(e.mw));
            cmp(e.nm, "mem_to_reg", 32'(bus.o_mem_to_reg), 32'(e.mtr));
            cmp(e.nm, "load_use", 32'(bus.o_load_use_stall), 32'(e.lus));
            if (e.dp) begin
                cmp(e.nm, "a", bus.o_a, e.a);
                cmp(e.nm, "b", bus.o_b, e.b);
                cmp(e.nm, "write_dat", bus.o_write_dat, e.wd);
                cmp(e.nm, "write_reg", 32'(bus.o_write_reg), 32'(e.wr));
                cmp(e.nm, "alu_ctrl", 32'(bus.o_alu_ctrl), 32'(e.aluc));
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] wd, input logic [4:0] wr, input logic [2:0] aluc,
                                input logic rw, input logic mw, input logic mtr, input logic vld,
                                input logic lus, input logic dp);
        exp_t e;
        e.nm = nm; e.a = a; e.b = b; e.wd = wd; e.wr = wr; e.aluc = aluc;
        e.rw = rw; e.mw = mw; e.mtr = mtr; e.vld = vld; e.lus = lus; e.dp = dp;
        return e;
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_dat, input logic [31:0] rt_dat, input logic [31:0] imm,
                          input logic [2:0] alu, input logic alu_src, input logic reg_dst,
                          input logic rw, input logic mw, input logic mtr, input logic vld);
        bus.i_rs = rs; bus.i_rt = rt; bus.i_rd = rd;
        bus.i_rs_dat = rs_dat; bus.i_rt_dat = rt_dat; bus.i_imm_ext = imm;
        bus.i_alu_ctrl = alu; bus.i_alu_src = alu_src; bus.i_reg_dst = reg_dst;
        bus.i_reg_write = rw; bus.i_mem_write = mw; bus.i_mem_to_reg = mtr; bus.i_in_vld = vld;
    endtask

    task automatic set_fwd(input logic exm_we, input logic [4:0] exm_rd, input logic [31:0] exm_res,
                           input logic mwb_we, input logic [4:0] mwb_rd, input logic [31:0] mwb_res);
        bus.i_exm_reg_write = exm_we; bus.i_exm_rd = exm_rd; bus.i_exm_result = exm_res;
        bus.i_mwb_reg_write = mwb_we; bus.i_mwb_rd = mwb_rd; bus.i_mwb_result = mwb_res;
    endtask

    // One active edge with current inputs, then queue the expected post-edge view.
    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Same, but with the stage stalled so only combinational paths may move.
    task automatic hold(input exp_t e);
        bus.i_stall = 1'b1;
        step(e);
        bus.i_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(mk("reset", 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 1));
        rst = 1'b0;

        // Basic ADD capture, then stall must ignore changed inputs.
        set_in(5'd1, 5'd2, 5'd4, 32'h5, 32'h7, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(mk("add", 32'h5, 32'h7, 32'h7, 5'd4, 3'd0, 1, 0, 0, 1, 0, 1));
        set_in(5'd1, 5'd2, 5'd10, 32'h99, 32'h98, 32'h0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        hold(mk("stall_hold", 32'h5, 32'h7, 32'h7, 5'd4, 3'd0, 1, 0, 0, 1, 0, 1));

        // Immediate operand, rt destination, store controls.
        set_in(5'd5, 5'd6, 5'd9, 32'h1234, 32'hABCD, 32'hFFFF_FFFC, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(mk("imm_slt", 32'h1234, 32'hFFFF_FFFC, 32'hABCD, 5'd6, 3'd5, 0, 1, 0, 1, 0, 1));

        // Invalid capture must squash controls but still register the datapath.
        set_in(5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(mk("invalid", 32'h11, 32'h22, 32'h22, 5'd9, 3'd2, 0, 0, 0, 0, 0, 1));

        // Forwarding priority and r0 exclusion (expect register data when disabled).
        set_in(5'd3, 5'd4, 5'd7, 32'h5, 32'h6, 32'h0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        step(mk("fwd_exm", FWD ? 32'h10 : 32'h5, 32'h6, 32'h6, 5'd7, 3'd1, 1, 0, 0, 1, 0, 1));
        set_fwd(1'b1, 5'd5, 32'h10, 1'b1, 5'd3, 32'h20);
        hold(mk("fwd_mwb", FWD ? 32'h20 : 32'h5, 32'h6, 32'h6, 5'd7, 3'd1, 1, 0, 0, 1, 0, 1));
        set_fwd(1'b1, 5'd5, 32'h10, 1'b1, 5'd4, 32'h20);
        hold(mk("fwd_rt", 32'h5, FWD ? 32'h20 : 32'h6, FWD ? 32'h20 : 32'h6, 5'd7, 3'd1, 1, 0, 0, 1, 0, 1));
        set_in(5'd0, 5'd0, 5'd7, 32'h77, 32'h66, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
        step(mk("fwd_r0", 32'h77, 32'h66, 32'h66, 5'd7, 3'd0, 1, 0, 0, 1, 0, 1));
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Load to r8: incoming rt=8 collides on the same cycle it lands.
        set_in(5'd1, 5'd8, 5'd3, 32'h100, 32'h200, 32'h4, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(mk("load", 32'h100, 32'h4, 32'h200, 5'd8, 3'd0, 1, 0, 1, 1, 1, 1));
        set_in(5'd2, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(mk("lus_rt9", 32'h100, 32'h4, 32'h200, 5'd8, 3'd0, 1, 0, 1, 1, 0, 1));
        set_in(5'd8, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(mk("lus_gate", 32'h100, 32'h4, 32'h200, 5'd8, 3'd0, 1, 0, 1, 1, 0, 1));
        set_in(5'd8, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(mk("lus_rs8", 32'h100, 32'h4, 32'h200, 5'd8, 3'd0, 1, 0, 1, 1, 1, 1));
        set_in(5'd0, 5'd0, 5'd3, 32'h1, 32'h2, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(mk("lus_r0", 32'h1, 32'h2, 32'h2, 5'd0, 3'd0, 1, 0, 1, 1, 0, 1));

        // Flush beats a simultaneous stall.
        set_in(5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'h0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(mk("pre_flush", 32'hA, 32'hB, 32'hB, 5'd3, 3'd4, 1, 1, 0, 1, 0, 1));
        bus.i_flush = 1'b1;
        hold(mk("flush_stall", 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 0));
        bus.i_flush = 1'b0;

        // Asynchronous reset between edges while stalled, then first capture after release.
        set_in(5'd1, 5'd2, 5'd3, 32'hC, 32'hD, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(mk("pre_reset", 32'hC, 32'hD, 32'hD, 5'd3, 3'd2, 1, 1, 1, 1, 0, 1));
        bus.i_stall = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        q.push_back(mk("async_reset", 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.i_stall = 1'b0;
        set_in(5'd1, 5'd2, 5'd3, 32'h5A, 32'h5B, 32'h0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(mk("post_reset", 32'h5A, 32'h5B, 32'h5B, 5'd3, 3'd1, 1, 0, 0, 1, 0, 1));

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
